// File: rtl/config_chain_loader.sv
// Serial loader for the CGRA config chain: takes 32-bit words, shifts CHAIN_LENGTH bits LSB-first, then checks an XOR checksum.
// Latency: word_ready one cycle after start; the first chain_shift comes one cycle after a word is accepted; one shift per cycle after that.
// Backpressure: when word_valid is low the loader stalls in FETCH/CHECK with chain_shift low, and no bits are lost.
module config_chain_loader #(
   parameter int CHAIN_LENGTH = 4096
) (
   input  logic        Config_Clock,
   input  logic        Config_Reset,
   input  logic        start,
   input  logic        abort,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   output logic        word_ready,
   output logic        ConfigIn,
   output logic        chain_shift,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int BL_W = $clog2(CHAIN_LENGTH + 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CHECK, DONE} state_t;

   state_t          state;
   logic [31:0]     shreg;      // bits of the current word not yet presented on ConfigIn
   logic [31:0]     acc;        // XOR of every data word accepted in this load
   logic [BL_W-1:0] bits_left;  // chain bits still to be shifted in this load
   logic [5:0]      cnt;        // shifts remaining for the current word
   logic [31:0]     bl_ext;
   logic            accept;

   assign bl_ext = 32'(bits_left);
   // word_ready is registered, so accept never feeds back into word_ready combinationally
   assign accept = word_valid & word_ready;

   // Load sequencer: a single state machine with every output registered
   always_ff @(posedge Config_Clock or posedge Config_Reset) begin
      if (Config_Reset) begin
         state       <= IDLE;
         shreg       <= '0;
         acc         <= '0;
         bits_left   <= '0;
         cnt         <= '0;
         word_ready  <= 1'b0;
         ConfigIn    <= 1'b0;
         chain_shift <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else if (abort && state != IDLE) begin
         // abort wins over everything else, including a simultaneous start
         state       <= IDLE;
         word_ready  <= 1'b0;
         ConfigIn    <= 1'b0;
         chain_shift <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start && !abort) begin
                  state      <= FETCH;
                  word_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  acc        <= '0;
                  bits_left  <= BL_W'(CHAIN_LENGTH);
               end
            end
            FETCH: begin
               if (accept) begin
                  // bit 0 goes straight to ConfigIn; the rest wait in shreg
                  state       <= SHIFT;
                  word_ready  <= 1'b0;
                  chain_shift <= 1'b1;
                  ConfigIn    <= word_data[0];
                  shreg       <= word_data >> 1;
                  acc         <= acc ^ word_data;
                  cnt         <= (bl_ext >= 32'd32) ? 6'd32 : bl_ext[5:0];
               end
            end
            SHIFT: begin
               ConfigIn  <= shreg[0];
               shreg     <= shreg >> 1;
               bits_left <= bits_left - BL_W'(1);
               cnt       <= cnt - 6'd1;
               if (cnt == 6'd1) begin
                  // this is the last shift of the word; any unshifted high bits of a partial word are dropped
                  chain_shift <= 1'b0;
                  ConfigIn    <= 1'b0;
                  word_ready  <= 1'b1;
                  state       <= (bl_ext == 32'd1) ? CHECK : FETCH;
               end
            end
            CHECK: begin
               if (accept) begin
                  state      <= DONE;
                  word_ready <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  error      <= (word_data != acc);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: three instances (40, 64 and 1 chain bits) driven one at a time.
// The expected serial stream, checksum verdict and cycle counts are computed from the word list.
// Every cycle is sampled on the falling clock edge.
module tb_config_chain_loader;

   localparam int LEN0 = 40;
   localparam int LEN1 = 64;
   localparam int LEN2 = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_v [3];
   logic        abort_v [3];
   logic        word_valid;
   logic [31:0] word_data;
   logic        w_rdy [3];
   logic        cfg   [3];
   logic        shf   [3];
   logic        bsy   [3];
   logic        dn    [3];
   logic        er    [3];

   int          n_tests  = 0;
   int          n_fail   = 0;
   int          sel      = 0;
   int          busy_cnt = 0;
   bit          capq  [$];
   bit          prevq [$];
   logic [31:0] wq    [$];

   always #5 clk = ~clk;

   config_chain_loader #(.CHAIN_LENGTH(LEN0)) u0 (
      .Config_Clock(clk), .Config_Reset(rst), .start(start_v[0]), .abort(abort_v[0]),
      .word_valid(word_valid), .word_data(word_data), .word_ready(w_rdy[0]), .ConfigIn(cfg[0]),
      .chain_shift(shf[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0]));
   config_chain_loader #(.CHAIN_LENGTH(LEN1)) u1 (
      .Config_Clock(clk), .Config_Reset(rst), .start(start_v[1]), .abort(abort_v[1]),
      .word_valid(word_valid), .word_data(word_data), .word_ready(w_rdy[1]), .ConfigIn(cfg[1]),
      .chain_shift(shf[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1]));
   config_chain_loader #(.CHAIN_LENGTH(LEN2)) u2 (
      .Config_Clock(clk), .Config_Reset(rst), .start(start_v[2]), .abort(abort_v[2]),
      .word_valid(word_valid), .word_data(word_data), .word_ready(w_rdy[2]), .ConfigIn(cfg[2]),
      .chain_shift(shf[2]), .busy(bsy[2]), .done(dn[2]), .error(er[2]));

   function automatic int len_of(input int d);
      case (d)
         0:       return LEN0;
         1:       return LEN1;
         default: return LEN2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance to the next falling edge and record the selected instance's serial activity.
   task automatic tick();
      @(negedge clk);
      if (shf[sel]) capq.push_back(cfg[sel]);
      if (bsy[sel]) busy_cnt++;
   endtask

   task automatic send_word(input logic [31:0] w, input string tag);
      bit got;
      got = 1'b0;
      word_valid = 1'b1;
      word_data  = w;
      for (int c = 0; c < 100 && !got; c++) begin
         if (w_rdy[sel]) got = 1'b1;
         tick();
      end
      chk({tag, "_accept"}, 64'(got), 64'd1);
   endtask

   task automatic wait_ready(input string tag);
      bit got;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         if (w_rdy[sel]) got = 1'b1;
         else tick();
      end
      chk({tag, "_ready_wait"}, 64'(got), 64'd1);
   endtask

   task automatic fill_random(input int d);
      wq.delete();
      for (int i = 0; i < (len_of(d) + 31) / 32; i++) wq.push_back($urandom);
   endtask

   // Full load of the words in wq followed by checksum cs, checked against values computed from wq.
   task automatic run_load(input int d, input logic [31:0] cs, input int gap_len, input string tag);
      int          len;
      int          nw;
      int          mism;
      logic [31:0] x;
      logic [31:0] cur;
      len = len_of(d);
      nw  = (len + 31) / 32;
      sel = d;
      capq.delete();
      busy_cnt = 0;
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      chk({tag, "_rdy_after_start"}, 64'(w_rdy[d]), 64'd1);
      for (int i = 0; i < wq.size(); i++) begin
         if (i == 1 && gap_len > 0) begin
            word_valid = 1'b0;
            wait_ready(tag);
            for (int g = 0; g < gap_len; g++) begin
               tick();
               chk({tag, "_gap_shift"}, 64'(shf[d]), 64'd0);
            end
            chk({tag, "_gap_rdy"}, 64'(w_rdy[d]), 64'd1);
         end
         send_word(wq[i], tag);
      end
      send_word(cs, tag);
      word_valid = 1'b0;
      x = 32'd0;
      foreach (wq[i]) x ^= wq[i];
      mism = 0;
      for (int i = 0; i < len; i++) begin
         cur = wq[i / 32];
         if (i >= capq.size() || capq[i] != cur[i % 32]) mism++;
      end
      chk({tag, "_done"}, 64'(dn[d]), 64'd1);
      chk({tag, "_error"}, 64'(er[d]), 64'(cs != x));
      chk({tag, "_busy_low"}, 64'(bsy[d]), 64'd0);
      chk({tag, "_nshift"}, 64'(capq.size()), 64'(len));
      chk({tag, "_stream"}, 64'(mism), 64'd0);
      chk({tag, "_cycles"}, 64'(busy_cnt), 64'(len + nw + 1 + gap_len));
      repeat (3) tick();
      chk({tag, "_nshift_after"}, 64'(capq.size()), 64'(len));
      chk({tag, "_done_sticky"}, 64'(dn[d]), 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          mism;
      logic [31:0] cs;
      rst = 1'b1;
      word_valid = 1'b0;
      word_data  = 32'd0;
      for (int d = 0; d < 3; d++) begin
         start_v[d] = 1'b0;
         abort_v[d] = 1'b0;
      end
      repeat (3) tick();
      for (int d = 0; d < 3; d++)
         chk($sformatf("reset_outs_%0d", d),
             64'({w_rdy[d], cfg[d], shf[d], bsy[d], dn[d], er[d]}), 64'd0);
      rst = 1'b0;
      tick();

      // 40-bit chain with the directed words, correct and wrong checksum
      wq.delete();
      wq.push_back(32'hA5A5A5A5);
      wq.push_back(32'h000000C3);
      run_load(0, 32'hA5A5A566, 0, "l40_good");
      chk("l40_tail_bits", 64'({capq[32], capq[33], capq[34], capq[35],
                                capq[36], capq[37], capq[38], capq[39]}), 64'b11000011);
      run_load(0, 32'h00000000, 0, "l40_bad");

      // 64-bit chain with and without a 5-cycle stall between words
      fill_random(1);
      cs = wq[0] ^ wq[1];
      run_load(1, cs, 0, "l64_nogap");
      prevq = capq;
      run_load(1, cs, 5, "l64_gap");
      mism = 0;
      for (int i = 0; i < LEN1; i++)
         if (i >= capq.size() || i >= prevq.size() || capq[i] != prevq[i]) mism++;
      chk("l64_gap_same_stream", 64'(mism), 64'd0);

      // abort on the 10th shift cycle, then a clean load
      sel = 1;
      capq.delete();
      start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      send_word($urandom, "abort_w0");
      word_valid = 1'b0;
      for (int c = 0; c < 100 && capq.size() < 10; c++) tick();
      chk("abort_at_shift10", 64'(capq.size()), 64'd10);
      chk("abort_shift_high", 64'(shf[1]), 64'd1);
      abort_v[1] = 1'b1;
      tick();
      abort_v[1] = 1'b0;
      chk("abort_outs", 64'({bsy[1], shf[1], er[1], dn[1], w_rdy[1]}), 64'b00100);
      tick();
      chk("abort_no_more_shift", 64'(capq.size()), 64'd10);
      fill_random(1);
      run_load(1, wq[0] ^ wq[1], 0, "after_abort");

      // asynchronous reset in the middle of shifting
      sel = 0;
      capq.delete();
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      send_word($urandom, "rst_w0");
      word_valid = 1'b0;
      repeat (3) tick();
      chk("rst_pre_shift", 64'(shf[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_outs", 64'({w_rdy[0], cfg[0], shf[0], bsy[0], dn[0], er[0]}), 64'd0);
      n = capq.size();
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("rst_no_shift_after", 64'(capq.size()), 64'(n));

      // start together with abort while idle
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      chk("start_abort_idle", 64'({w_rdy[0], bsy[0], er[0]}), 64'd0);
      tick();
      chk("start_abort_idle2", 64'(w_rdy[0]), 64'd0);

      // single-bit chain
      wq.delete();
      wq.push_back(32'hFFFFFFFE);
      run_load(2, 32'hFFFFFFFE, 0, "l1");
      chk("l1_bit0", 64'(capq.size() > 0 ? capq[0] : 1'b1), 64'd0);

      // randomized loads across all three chain lengths
      for (int r = 0; r < 6; r++) begin
         int d;
         d = r % 3;
         fill_random(d);
         cs = 32'd0;
         foreach (wq[i]) cs ^= wq[i];
         if ($urandom_range(0, 1) == 1) cs ^= (32'd1 << $urandom_range(0, 31));
         run_load(d, cs, (r == 4) ? 3 : 0, $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
